dynamic_segment: RTL and testbench
==================================

Name: dynamic_segment

Overview:
- Four-digit multiplexed 7-segment driver for a minutes:seconds clock display (MM:SS).
- Contains a 1 Hz tick prescaler, a BCD MM:SS counter, a digit-scan divider, a digit multiplexer and a segment decoder.
- Sits at board top level; `com` drives the digit commons and `data` drives the shared segment lines of a 4-digit common-anode display.

Parameters:
- TICK_DIV, 10_000_000: clocks per counter increment (1 s at a 10 MHz `clk`); legal range ≥ 2.
- SCAN_DIV, 10_000: clocks per scanned digit (1 kHz digit rate at 10 MHz); legal range ≥ 1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- com  output  4  digit enables, active-low, one-hot-zero; com[0] = rightmost digit.
- data  output  8  segments, active-low; bit0=a … bit6=g, bit7=dp.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While reset=0, all registers clear:
  - prescaler=0, scan counter=0, scan index=0, all BCD digits=0.
  - Outputs: com=4'b1111 (all digits off), data=8'hFF (all segments off).
- Prescaler: counts 0..TICK_DIV-1 and wraps. A one-clock `tick` pulses when the count equals TICK_DIV-1.
- Time counter: increments on `tick`. Digits are sec_ones (0-9), sec_tens (0-5), min_ones (0-9), min_tens (0-5).
  - Carries ripple in the same clock.
  - 00:09→00:10, 00:59→01:00, 09:59→10:00, 59:59→00:00 (wrap, no flag).
- Scan counter: counts 0..SCAN_DIV-1. On reaching SCAN_DIV-1, scan index advances 0→1→2→3→0.
- Digit mapping by scan index:
  - 0 = sec_ones on com[0]
  - 1 = sec_tens on com[1]
  - 2 = min_ones on com[2]
  - 3 = min_tens on com[3]
- Outputs are registered and update every clock from the current scan index and digit values (one clock latency).
  - com = ~(4'b0001 << index).
  - data = {dp, seg(digit)}.
  - First edge after reset release: com=4'b1110, data=8'hC0.
- Segment code (active-low, 8-bit with dp=1): 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90. Any non-BCD value → FF (blank).
- Simultaneous tick and scan advance: both take effect on the same edge. Displayed digit reflects the new value on the following clock.
- Reset mid-operation: immediate return to reset values regardless of state.

Optional Feature:
- Macro: DYNAMIC_SEGMENT_DP_BLINK_EN.
- Defined: dp (data[7]) = 0 (lit) on scan index 2 while prescaler < TICK_DIV/2, otherwise 1. This gives a blinking colon between MM and SS.
- Undefined: data[7] is always 1.

Decomposition:
- Package dynamic_segment_pkg holds:
  - the segment code constants SEG_0..SEG_9 and SEG_BLANK=8'hFF;
  - a 2-bit digit-index typedef;
  - a 4-bit BCD typedef.
- One sub-module, seg7_decode: combinational 4-bit BCD in → 7-bit active-low segments out.

Test Plan:
- Reset held low for 100 ns, then high (TICK_DIV=10, SCAN_DIV=4) → during reset com=1111, data=FF; first edge after release com=1110, data=C0.
- Scan check, 16 clocks after reset → com cycles 1110, 1101, 1011, 0111, each held 4 clocks; data=C0 throughout while time is 00:00.
- 10 ticks (100 clocks) → sec_ones goes 1..9 then 0 with sec_tens=1; while com=1101, data=F9.
- Force 59:59 then apply one tick → display 00:00; all four digits show C0.
- Assert reset mid-count at 12:34 → com=1111 and data=FF asynchronously (before the next clock edge); after release, 00:00 is shown.
- With DYNAMIC_SEGMENT_DP_BLINK_EN, TICK_DIV=10 → data[7]=0 on com=1011 while prescaler<5, and 1 otherwise; without the macro, data[7]=1 always.

Source files
------------

// File: rtl/dynamic_segment_pkg.sv
// Shared types and active-low segment codes for the dynamic_segment MM:SS display driver.
package dynamic_segment_pkg;

   typedef logic [1:0] digit_idx_t;
   typedef logic [3:0] bcd_t;

   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // Active-low one-hot digit common for a scan index.
   function automatic logic [3:0] com_sel(input digit_idx_t idx);
      return ~(4'b0001 << idx);
   endfunction

endpackage

// File: rtl/dynamic_segment_seg7_decode.sv
// seg7_decode: combinational BCD to active-low 7-segment (bit0=a .. bit6=g); non-BCD blanks.
module seg7_decode
   import dynamic_segment_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK[6:0];
      case (bcd)
         4'd0: seg = SEG_0[6:0];
         4'd1: seg = SEG_1[6:0];
         4'd2: seg = SEG_2[6:0];
         4'd3: seg = SEG_3[6:0];
         4'd4: seg = SEG_4[6:0];
         4'd5: seg = SEG_5[6:0];
         4'd6: seg = SEG_6[6:0];
         4'd7: seg = SEG_7[6:0];
         4'd8: seg = SEG_8[6:0];
         4'd9: seg = SEG_9[6:0];
         default: seg = SEG_BLANK[6:0];
      endcase
   end

endmodule

// File: rtl/dynamic_segment.sv
// Four-digit multiplexed MM:SS 7-segment driver with 1 Hz prescaler and digit scanning.
// Define DYNAMIC_SEGMENT_DP_BLINK_EN to blink the dp on digit 2 as a colon.
module dynamic_segment
   import dynamic_segment_pkg::*;
#(
   parameter int TICK_DIV = 10_000_000,
   parameter int SCAN_DIV = 10_000
) (
   input  logic       clk,
   input  logic       reset,
   output logic [3:0] com,
   output logic [7:0] data
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);
   localparam logic [PW-1:0] PRE_HALF = PW'(TICK_DIV / 2);
   localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);

   logic [PW-1:0] presc;
   logic [SW-1:0] scan_cnt;
   digit_idx_t    idx;
   bcd_t          sec_ones, sec_tens, min_ones, min_tens;
   logic          tick, scan_adv, dp;
   bcd_t          cur;
   logic [6:0]    seg;

   always_comb begin
      tick     = (presc == PRE_MAX);
      scan_adv = (scan_cnt == SCAN_MAX);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         presc <= '0;
      end else if (tick) begin
         presc <= '0;
      end else begin
         presc <= presc + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scan_cnt <= '0;
         idx      <= '0;
      end else if (scan_adv) begin
         scan_cnt <= '0;
         idx      <= idx + 2'd1;
      end else begin
         scan_cnt <= scan_cnt + SW'(1);
      end
   end

   // Carries ripple through all four digits on the same tick edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sec_ones <= '0;
         sec_tens <= '0;
         min_ones <= '0;
         min_tens <= '0;
      end else if (tick) begin
         if (sec_ones == 4'd9) begin
            sec_ones <= '0;
            if (sec_tens == 4'd5) begin
               sec_tens <= '0;
               if (min_ones == 4'd9) begin
                  min_ones <= '0;
                  if (min_tens == 4'd5) begin
                     min_tens <= '0;
                  end else begin
                     min_tens <= min_tens + 4'd1;
                  end
               end else begin
                  min_ones <= min_ones + 4'd1;
               end
            end else begin
               sec_tens <= sec_tens + 4'd1;
            end
         end else begin
            sec_ones <= sec_ones + 4'd1;
         end
      end
   end

   always_comb begin
      cur = sec_ones;
      case (idx)
         2'd0: cur = sec_ones;
         2'd1: cur = sec_tens;
         2'd2: cur = min_ones;
         2'd3: cur = min_tens;
         default: cur = sec_ones;
      endcase
   end

   always_comb begin
`ifdef DYNAMIC_SEGMENT_DP_BLINK_EN
      dp = !((idx == 2'd2) && (presc < PRE_HALF));
`else
      dp = 1'b1;
`endif
   end

   seg7_decode u_dec (
      .bcd (cur),
      .seg (seg)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         com  <= '1;
         data <= '1;
      end else begin
         com  <= com_sel(idx);
         data <= {dp, seg};
      end
   end

endmodule

// File: tb/tb_dynamic_segment.sv
// Self-checking bench for dynamic_segment: arithmetic time/scan model plus pinned literal checks.
module tb_dynamic_segment;

   localparam int TICK_DIV = 10;
   localparam int SCAN_DIV = 4;

   logic       clk   = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] com;
   logic [7:0] data;

   int unsigned ecount = 0;
   int          tests  = 0;
   int          fails  = 0;

   dynamic_segment #(
      .TICK_DIV (TICK_DIV),
      .SCAN_DIV (SCAN_DIV)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .com   (com),
      .data  (data)
   );

   always #5 clk = ~clk;

   // Rising edges seen since reset was last released.
   always @(posedge clk or negedge reset) begin
      if (!reset) ecount <= 0;
      else        ecount <= ecount + 1;
   end

   function automatic logic [7:0] seg_of(input int unsigned d);
      case (d)
         0: return 8'hC0;
         1: return 8'hF9;
         2: return 8'hA4;
         3: return 8'hB0;
         4: return 8'h99;
         5: return 8'h92;
         6: return 8'h82;
         7: return 8'hF8;
         8: return 8'h80;
         9: return 8'h90;
         default: return 8'hFF;
      endcase
   endfunction

   // Outputs after edge e show the state that existed before that edge (k = e-1 clocks elapsed).
   function automatic logic [11:0] model(input int unsigned e);
      int unsigned k, pos, secs, d;
      logic [3:0]  c;
      logic [7:0]  s;
      if (e == 0) return 12'hFFF;
      k    = e - 1;
      pos  = (k / SCAN_DIV) % 4;
      secs = (k / TICK_DIV) % 3600;
      case (pos)
         0: d = secs % 10;
         1: d = (secs / 10) % 6;
         2: d = (secs / 60) % 10;
         default: d = (secs / 600) % 6;
      endcase
      c = 4'hF;
      c[pos] = 1'b0;
      s = seg_of(d);
`ifdef DYNAMIC_SEGMENT_DP_BLINK_EN
      if (pos == 2 && (k % TICK_DIV) < TICK_DIV / 2) s[7] = 1'b0;
`endif
      return {c, s};
   endfunction

   always @(negedge clk) begin
      logic [11:0] exp_v;
      exp_v = model(ecount);
      tests++;
      if ({com, data} !== exp_v) begin
         fails++;
         $display("FAIL model e=%0d com=%b data=%h expected com=%b data=%h",
                  ecount, com, data, exp_v[11:8], exp_v[7:0]);
      end
   end

   task automatic chk(input string name, input logic [3:0] c, input logic [7:0] d);
      tests++;
      if (com !== c || data !== d) begin
         fails++;
         $display("FAIL %s com=%b data=%h expected com=%b data=%h", name, com, data, c, d);
      end
   endtask

   task automatic wait_edge(input int unsigned n);
      int unsigned guard = 0;
      while (ecount < n && guard < n + 100) begin
         @(negedge clk);
         guard++;
      end
      if (ecount != n) begin
         tests++;
         fails++;
         $display("FAIL wait_edge reached=%0d expected=%0d", ecount, n);
      end
   endtask

   initial begin
      logic [7:0] blink_exp;
`ifdef DYNAMIC_SEGMENT_DP_BLINK_EN
      blink_exp = 8'h40;
`else
      blink_exp = 8'hC0;
`endif
      #50 chk("rst_hold", 4'b1111, 8'hFF);
      #52 reset = 1'b1;

      wait_edge(1);     chk("first_edge", 4'b1110, 8'hC0);
      wait_edge(5);     chk("scan_d1", 4'b1101, 8'hC0);
      wait_edge(9);     chk("scan_d2_dp_off", 4'b1011, 8'hC0);
      wait_edge(11);    chk("scan_d2_dp_blink", 4'b1011, blink_exp);
      wait_edge(101);   chk("sec_10", 4'b1101, 8'hF9);
      wait_edge(7541);  chk("t1234_sectens", 4'b1101, 8'hB0);
      wait_edge(7549);  chk("t1234_mintens", 4'b0111, 8'hF9);

      @(posedge clk);
      #2 reset = 1'b0;
      #1 chk("async_rst", 4'b1111, 8'hFF);
      #20;
      @(negedge clk);
      #2 reset = 1'b1;
      wait_edge(1);     chk("after_rst", 4'b1110, 8'hC0);

      wait_edge(35997); chk("t5959_mintens", 4'b0111, 8'h92);
      wait_edge(36001); chk("wrap_0000", 4'b1110, 8'hC0);
      wait_edge(36017);

      for (int r = 0; r < 4; r++) begin
         repeat ($urandom_range(20, 400)) @(posedge clk);
         if ($urandom_range(0, 1) == 1) @(negedge clk);
         #($urandom_range(1, 3));
         reset = 1'b0;
         #1 chk("rand_async_rst", 4'b1111, 8'hFF);
         repeat ($urandom_range(1, 3)) @(posedge clk);
         @(negedge clk);
         #2 reset = 1'b1;
         wait_edge(1);
         chk("rand_after_rst", 4'b1110, 8'hC0);
      end
      repeat (50) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
